clk_enable_gen: RTL and testbench



---
 rtl/clk_enable_gen.sv | 115 +++++++++++
 tb/tb_clk_enable_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_gen.sv
// One-clock strobe generator: register/radix/counter enable pulses with run/halt/single-step control.
// Optional CYCLE_CNT counter of EN_CNT pulses is built when CLK_ENABLE_GEN_CYCLE_CNT_EN is defined.
module clk_enable_gen #(
    parameter int REG_DIV   = 1,
    parameter int RADIX_DIV = 5,
    parameter int CNT_DIV   = 6,
    parameter int CW        = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          RUN,
    input  logic          STEP_REQ,
    output logic          EN_REG,
    output logic          EN_RADIX,
    output logic          EN_CNT,
    output logic          BUSY,
    output logic          STEP_DONE,
    output logic [CW-1:0] CYCLE_CNT
);

    localparam int RW = (REG_DIV   > 1) ? $clog2(REG_DIV)   : 1;
    localparam int XW = (RADIX_DIV > 1) ? $clog2(RADIX_DIV) : 1;
    localparam int NW = (CNT_DIV   > 1) ? $clog2(CNT_DIV)   : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUNNING  = 2'd1;
    localparam logic [1:0] STEPPING = 2'd2;
    localparam logic [1:0] DRAIN    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] reg_ph_q, reg_ph_d;
    logic [XW-1:0] radix_ph_q, radix_ph_d;
    logic [NW-1:0] cnt_ph_q, cnt_ph_d;
    logic          busy_q, step_done_q, step_done_d;
    logic          active;

    // Enables are decoded from registered state, so they are glitch-free Moore outputs.
    assign active   = (state_q != IDLE);
    assign EN_REG   = active && (reg_ph_q   == RW'(REG_DIV - 1));
    assign EN_RADIX = active && (radix_ph_q == XW'(RADIX_DIV - 1));
    assign EN_CNT   = active && (cnt_ph_q   == NW'(CNT_DIV - 1));
    assign BUSY      = busy_q;
    assign STEP_DONE = step_done_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d     = state_q;
        step_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (RUN)           state_d = RUNNING;
                else if (STEP_REQ) state_d = STEPPING;
            end
            RUNNING: begin
                if (!RUN) state_d = EN_CNT ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (RUN)         state_d = RUNNING;
                else if (EN_CNT) state_d = IDLE;
            end
            STEPPING: begin
                if (EN_CNT) begin
                    state_d     = IDLE;
                    step_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Phases hold at zero in IDLE so the first active cycle always starts at phase 0.
    always_comb begin
        reg_ph_d   = '0;
        radix_ph_d = '0;
        cnt_ph_d   = '0;
        if (active && (state_d != IDLE)) begin
            reg_ph_d   = (reg_ph_q   == RW'(REG_DIV - 1))   ? '0 : reg_ph_q   + 1'b1;
            radix_ph_d = (radix_ph_q == XW'(RADIX_DIV - 1)) ? '0 : radix_ph_q + 1'b1;
            cnt_ph_d   = (cnt_ph_q   == NW'(CNT_DIV - 1))   ? '0 : cnt_ph_q   + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            reg_ph_q    <= '0;
            radix_ph_q  <= '0;
            cnt_ph_q    <= '0;
            busy_q      <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_ph_q    <= reg_ph_d;
            radix_ph_q  <= radix_ph_d;
            cnt_ph_q    <= cnt_ph_d;
            busy_q      <= (state_d != IDLE);
            step_done_q <= step_done_d;
        end
    end

`ifdef CLK_ENABLE_GEN_CYCLE_CNT_EN
    logic [CW-1:0] cycle_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST)         cycle_cnt_q <= '0;
        else if (EN_CNT) cycle_cnt_q <= cycle_cnt_q + 1'b1;
    end

    assign CYCLE_CNT = cycle_cnt_q;
`else
    assign CYCLE_CNT = '0;
`endif

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed self-checking bench for clk_enable_gen: default instance plus a CW=4, CNT_DIV=1 instance.
module tb_clk_enable_gen;

`ifdef CLK_ENABLE_GEN_CYCLE_CNT_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RUN = 1'b0;
    logic        STEP_REQ = 1'b0;
    logic        EN_REG, EN_RADIX, EN_CNT, BUSY, STEP_DONE;
    logic [15:0] CYCLE_CNT;
    logic        w_en_reg, w_en_radix, w_en_cnt, w_busy, w_step_done;
    logic [3:0]  w_cycle_cnt;

    int assertions = 0;
    int failures   = 0;

    always #5 CLK = ~CLK;

    clk_enable_gen dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .STEP_REQ(STEP_REQ),
        .EN_REG(EN_REG), .EN_RADIX(EN_RADIX), .EN_CNT(EN_CNT),
        .BUSY(BUSY), .STEP_DONE(STEP_DONE), .CYCLE_CNT(CYCLE_CNT)
    );

    clk_enable_gen #(.CNT_DIV(1), .CW(4)) dut_w (
        .CLK(CLK), .RST(RST), .RUN(RUN), .STEP_REQ(STEP_REQ),
        .EN_REG(w_en_reg), .EN_RADIX(w_en_radix), .EN_CNT(w_en_cnt),
        .BUSY(w_busy), .STEP_DONE(w_step_done), .CYCLE_CNT(w_cycle_cnt)
    );

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic tick();
        @(negedge CLK);
    endtask

    // Leaves the bench in "cycle 0": idle, inputs set now are sampled at edge 1.
    task automatic do_reset();
        RST = 1'b1; RUN = 1'b0; STEP_REQ = 1'b0;
        repeat (2) tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            assertions++;
            if ({EN_REG, EN_RADIX, EN_CNT, BUSY, STEP_DONE} !== 5'b0 || CYCLE_CNT !== 16'd0) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: en/busy/done=%b cnt=%0d, required 00000 cnt=0",
                         c, {EN_REG, EN_RADIX, EN_CNT, BUSY, STEP_DONE}, CYCLE_CNT);
            end
            tick();
        end
    endtask

    task automatic test_free_run();
        logic [4:0] exp;
        do_reset();
        RUN = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            exp = {1'b1, (c % 5) == 0, (c % 6) == 0, 1'b1, 1'b0};
            assertions++;
            if ({EN_REG, EN_RADIX, EN_CNT, BUSY, STEP_DONE} !== exp) begin
                failures++;
                $display("FAIL free_run cycle %0d: reg/radix/cnt/busy/done=%b, required %b",
                         c, {EN_REG, EN_RADIX, EN_CNT, BUSY, STEP_DONE}, exp);
            end
            if (c == 30) RUN = 1'b0;
        end
        tick();
        assertions++;
        if (BUSY !== 1'b0 || CYCLE_CNT !== (CC_EN ? 16'd5 : 16'd0)) begin
            failures++;
            $display("FAIL free_run_end: busy=%b cycle_cnt=%0d, required busy=0 cycle_cnt=%0d",
                     BUSY, CYCLE_CNT, CC_EN ? 5 : 0);
        end
    endtask

    task automatic test_step();
        logic [4:0] exp;
        do_reset();
        STEP_REQ = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            STEP_REQ = (c == 3);
            exp = {c <= 6, c == 5, c == 6, c <= 6, c == 7};
            assertions++;
            if ({EN_REG, EN_RADIX, EN_CNT, BUSY, STEP_DONE} !== exp) begin
                failures++;
                $display("FAIL single_step cycle %0d: reg/radix/cnt/busy/done=%b, required %b",
                         c, {EN_REG, EN_RADIX, EN_CNT, BUSY, STEP_DONE}, exp);
            end
        end
    endtask

    task automatic test_halt_drain();
        do_reset();
        RUN = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 8) RUN = 1'b0;
            assertions++;
            if (EN_CNT !== (c == 6 || c == 12) || BUSY !== (c <= 12) || EN_REG !== (c <= 12)) begin
                failures++;
                $display("FAIL halt_drain cycle %0d: cnt=%b busy=%b reg=%b, required cnt=%b busy=%b reg=%b",
                         c, EN_CNT, BUSY, EN_REG, c == 6 || c == 12, c <= 12, c <= 12);
            end
        end
    endtask

    task automatic test_drain_resume();
        do_reset();
        RUN = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 8)  RUN = 1'b0;
            if (c == 10) RUN = 1'b1;
            assertions++;
            if (EN_CNT !== ((c % 6) == 0) || BUSY !== 1'b1) begin
                failures++;
                $display("FAIL drain_resume cycle %0d: cnt=%b busy=%b, required cnt=%b busy=1",
                         c, EN_CNT, BUSY, (c % 6) == 0);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        RUN = 1'b1; STEP_REQ = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            STEP_REQ = 1'b0;
            if (c == 12) RUN = 1'b0;
            assertions++;
            if (STEP_DONE !== 1'b0 || BUSY !== (c <= 12)) begin
                failures++;
                $display("FAIL run_and_step cycle %0d: done=%b busy=%b, required done=0 busy=%b",
                         c, STEP_DONE, BUSY, c <= 12);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        RUN = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            tick();
            RST = (c == 9);
            if (c == 10) begin
                assertions++;
                if ({EN_REG, EN_RADIX, EN_CNT, BUSY, STEP_DONE} !== 5'b0 || CYCLE_CNT !== 16'd0) begin
                    failures++;
                    $display("FAIL reset_mid_run cycle 10: en/busy/done=%b cnt=%0d, required 00000 cnt=0",
                             {EN_REG, EN_RADIX, EN_CNT, BUSY, STEP_DONE}, CYCLE_CNT);
                end
            end else if (c > 10) begin
                assertions++;
                if (EN_CNT !== (c == 16) || BUSY !== 1'b1) begin
                    failures++;
                    $display("FAIL restart cycle %0d: cnt=%b busy=%b, required cnt=%b busy=1",
                             c, EN_CNT, BUSY, c == 16);
                end
            end
        end
    endtask

    task automatic test_wrap_div1();
        do_reset();
        RUN = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c == 17) RUN = 1'b0;
            assertions++;
            if (w_en_cnt !== 1'b1 || w_en_reg !== 1'b1) begin
                failures++;
                $display("FAIL div1_enable cycle %0d: cnt=%b reg=%b, required cnt=1 reg=1",
                         c, w_en_cnt, w_en_reg);
            end
        end
        tick();
        assertions++;
        if (w_busy !== 1'b0 || w_cycle_cnt !== (CC_EN ? 4'd1 : 4'd0)) begin
            failures++;
            $display("FAIL cycle_cnt_wrap: busy=%b cycle_cnt=%0d, required busy=0 cycle_cnt=%0d",
                     w_busy, w_cycle_cnt, CC_EN ? 1 : 0);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_free_run();
        test_step();
        test_halt_drain();
        test_drain_resume();
        test_simultaneous();
        test_reset_mid_run();
        test_wrap_div1();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
